kf8237_channel_register_bank: RTL and testbench

//  Parametrised per-channel base/current address and word-count storage for the KF8237 DMA core.

---
 rtl/kf8237_pkg.sv | 35 +++
 rtl/kf8237_channel_counter.sv | 92 +++++++++
 rtl/kf8237_channel_register_bank.sv | 146 ++++++++++++++
 tb/tb_kf8237_channel_register_bank.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf8237_pkg.sv
// Shared constants and helpers for the KF8237 channel register bank.
package kf8237_pkg;

    localparam int MAX_CHANNELS  = 8;
    localparam int POINTER_WIDTH = 2;

    // Number of bus bytes in a register of the given bit width.
    function automatic int byte_count(input int width);
        return width / 8;
    endfunction

    // Pick one byte out of a (zero-extended) register value.
    function automatic logic [7:0] select_byte(input logic [31:0] value,
                                               input logic [POINTER_WIDTH-1:0] index);
        logic [7:0] result;
        case (index)
            2'd0:    result = value[7:0];
            2'd1:    result = value[15:8];
            2'd2:    result = value[23:16];
            default: result = value[31:24];
        endcase
        return result;
    endfunction

    // Index of the lowest set bit; 0 when nothing is set (callers test for that).
    function automatic logic [2:0] onehot_index(input logic [MAX_CHANNELS-1:0] value);
        logic [2:0] index;
        index = 3'd0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (value[i]) index = 3'(i);
        end
        return index;
    endfunction

endpackage

// File: rtl/kf8237_channel_counter.sv
// One DMA channel: base/current address and word count, byte loading,
// per-transfer stepping, terminal-count detection and autoinitialize reload.
module kf8237_channel_counter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               data,
    input  logic [1:0]               byte_pointer,
    input  logic                     write_address,
    input  logic                     write_count,
    input  logic                     step,
    input  logic                     end_of_process,
    input  logic                     autoinitialize,
    input  logic                     address_decrement,
    output logic [ADDR_WIDTH-1:0]    current_address,
    output logic [COUNT_WIDTH-1:0]   current_count,
    output logic                     terminal
);
    import kf8237_pkg::*;

    localparam int ADDR_BYTES  = byte_count(ADDR_WIDTH);
    localparam int COUNT_BYTES = byte_count(COUNT_WIDTH);

    logic [ADDR_WIDTH-1:0]  base_address_reg, base_address_next;
    logic [ADDR_WIDTH-1:0]  current_address_reg, current_address_next;
    logic [COUNT_WIDTH-1:0] base_count_reg, base_count_next;
    logic [COUNT_WIDTH-1:0] current_count_reg, current_count_next;
    logic [ADDR_WIDTH-1:0]  address_mask;
    logic [COUNT_WIDTH-1:0] count_mask;
    logic [ADDR_WIDTH-1:0]  address_fill;
    logic [COUNT_WIDTH-1:0] count_fill;
    logic [ADDR_WIDTH-1:0]  address_stepped;

    // Byte lane masks select the lane addressed by the shared byte pointer.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_BYTES; gi++) begin : g_address_lane
            assign address_mask[gi*8 +: 8] = {8{byte_pointer == POINTER_WIDTH'(gi)}};
        end
        for (gi = 0; gi < COUNT_BYTES; gi++) begin : g_count_lane
            assign count_mask[gi*8 +: 8] = {8{byte_pointer == POINTER_WIDTH'(gi)}};
        end
    endgenerate

    assign address_fill    = {ADDR_BYTES{data}};
    assign count_fill      = {COUNT_BYTES{data}};
    assign address_stepped = address_decrement ? current_address_reg - 1'b1
                                               : current_address_reg + 1'b1;
    assign terminal        = step & ((current_count_reg == '0) | end_of_process);

    // A CPU write to a register takes precedence over that register's step.
    always_comb begin
        base_address_next    = base_address_reg;
        current_address_next = current_address_reg;
        base_count_next      = base_count_reg;
        current_count_next   = current_count_reg;
        if (write_address) begin
            base_address_next    = (base_address_reg & ~address_mask) | (address_fill & address_mask);
            current_address_next = (current_address_reg & ~address_mask) | (address_fill & address_mask);
        end else if (step) begin
            current_address_next = (terminal && autoinitialize) ? base_address_reg : address_stepped;
        end
        if (write_count) begin
            base_count_next    = (base_count_reg & ~count_mask) | (count_fill & count_mask);
            current_count_next = (current_count_reg & ~count_mask) | (count_fill & count_mask);
        end else if (step) begin
            current_count_next = (terminal && autoinitialize) ? base_count_reg
                                                              : current_count_reg - 1'b1;
        end
    end

    // Register update with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_address_reg    <= '0;
            current_address_reg <= '0;
            base_count_reg      <= '0;
            current_count_reg   <= '0;
        end else begin
            base_address_reg    <= base_address_next;
            current_address_reg <= current_address_next;
            base_count_reg      <= base_count_next;
            current_count_reg   <= current_count_next;
        end
    end

    assign current_address = current_address_reg;
    assign current_count   = current_count_reg;

endmodule

// File: rtl/kf8237_channel_register_bank.sv
// Per-channel address/count storage for the KF8237 DMA core: shared byte
// pointer, byte-serial read mux, terminal-count pulse and sticky TC status.
module kf8237_channel_register_bank #(
    parameter int CHANNELS    = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             internal_data_bus,
    input  logic [CHANNELS-1:0]    write_base_and_current_address,
    input  logic [CHANNELS-1:0]    write_base_and_current_word_count,
    input  logic [CHANNELS-1:0]    read_current_address,
    input  logic [CHANNELS-1:0]    read_current_word_count,
    input  logic                   clear_byte_pointer,
    input  logic                   master_clear,
    input  logic                   read_status_register,
    input  logic [CHANNELS-1:0]    autoinitialize,
    input  logic [CHANNELS-1:0]    address_decrement,
    input  logic [CHANNELS-1:0]    active_channel,
    input  logic                   update,
    input  logic                   end_of_process_in,
    output logic [7:0]             data_bus_out,
    output logic [ADDR_WIDTH-1:0]  current_address_out,
    output logic                   terminal_count,
    output logic [CHANNELS-1:0]    terminal_count_status
);
    import kf8237_pkg::*;

    localparam logic [POINTER_WIDTH-1:0] ADDR_LAST  = POINTER_WIDTH'(byte_count(ADDR_WIDTH) - 1);
    localparam logic [POINTER_WIDTH-1:0] COUNT_LAST = POINTER_WIDTH'(byte_count(COUNT_WIDTH) - 1);

    logic [POINTER_WIDTH-1:0] byte_pointer_reg, byte_pointer_next, pointer_last;
    logic                     read_level, read_level_reg, read_fall, read_kind_reg;
    logic                     status_read_reg, terminal_count_reg;
    logic [CHANNELS-1:0]      status_reg, status_next;
    logic [CHANNELS-1:0]      write_address_sel, write_count_sel, active_sel, tc_ch;
    logic [MAX_CHANNELS-1:0]  read_address_pad, read_count_pad, active_pad;
    logic [ADDR_WIDTH-1:0]    address_ch [MAX_CHANNELS];
    logic [COUNT_WIDTH-1:0]   count_ch   [MAX_CHANNELS];

    // Isolate the lowest set bit so that several strobes act on one channel only.
    assign write_address_sel = write_base_and_current_address
                             & (~write_base_and_current_address + CHANNELS'(1));
    assign write_count_sel   = write_base_and_current_word_count
                             & (~write_base_and_current_word_count + CHANNELS'(1));
    assign active_sel        = active_channel & (~active_channel + CHANNELS'(1));

    assign read_address_pad  = MAX_CHANNELS'(read_current_address);
    assign read_count_pad    = MAX_CHANNELS'(read_current_word_count);
    assign active_pad        = MAX_CHANNELS'(active_channel);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_CHANNELS; gi++) begin : g_channel
            if (gi < CHANNELS) begin : g_used
                kf8237_channel_counter #(
                    .ADDR_WIDTH  (ADDR_WIDTH),
                    .COUNT_WIDTH (COUNT_WIDTH)
                ) u_counter (
                    .clock             (clock),
                    .reset             (reset),
                    .data              (internal_data_bus),
                    .byte_pointer      (byte_pointer_reg),
                    .write_address     (write_address_sel[gi]),
                    .write_count       (write_count_sel[gi]),
                    .step              (update & active_sel[gi]),
                    .end_of_process    (end_of_process_in),
                    .autoinitialize    (autoinitialize[gi]),
                    .address_decrement (address_decrement[gi]),
                    .current_address   (address_ch[gi]),
                    .current_count     (count_ch[gi]),
                    .terminal          (tc_ch[gi])
                );
            end else begin : g_unused
                assign address_ch[gi] = '0;
                assign count_ch[gi]   = '0;
            end
        end
    endgenerate

    // Byte-serial read mux; address reads take priority over count reads.
    always_comb begin
        data_bus_out = 8'h00;
        if (|read_current_address)
            data_bus_out = select_byte(32'(address_ch[onehot_index(read_address_pad)]), byte_pointer_reg);
        else if (|read_current_word_count)
            data_bus_out = select_byte(32'(count_ch[onehot_index(read_count_pad)]), byte_pointer_reg);
    end

    // Address of the channel in service, zero when idle.
    always_comb begin
        current_address_out = '0;
        if (|active_channel)
            current_address_out = address_ch[onehot_index(active_pad)];
    end

    assign read_level = (|read_current_address) | (|read_current_word_count);
    assign read_fall  = read_level_reg & ~read_level;

    // Pointer advance: writes step immediately, reads step once the read ends.
    always_comb begin
        byte_pointer_next = byte_pointer_reg;
        if (|write_base_and_current_address)
            pointer_last = ADDR_LAST;
        else if (|write_base_and_current_word_count)
            pointer_last = COUNT_LAST;
        else
            pointer_last = read_kind_reg ? ADDR_LAST : COUNT_LAST;
        if (clear_byte_pointer || master_clear)
            byte_pointer_next = '0;
        else if ((|write_base_and_current_address) || (|write_base_and_current_word_count) || read_fall)
            byte_pointer_next = (byte_pointer_reg >= pointer_last) ? '0 : byte_pointer_reg + 1'b1;
    end

    // Sticky TC flags: clears first, then a new terminal count sets its flag.
    always_comb begin
        status_next = status_reg;
        if (master_clear || (status_read_reg && !read_status_register))
            status_next = '0;
        status_next = status_next | tc_ch;
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_pointer_reg   <= '0;
            read_level_reg     <= 1'b0;
            read_kind_reg      <= 1'b0;
            status_read_reg    <= 1'b0;
            terminal_count_reg <= 1'b0;
            status_reg         <= '0;
        end else begin
            byte_pointer_reg   <= byte_pointer_next;
            read_level_reg     <= read_level;
            read_kind_reg      <= read_level ? (|read_current_address) : read_kind_reg;
            status_read_reg    <= read_status_register;
            terminal_count_reg <= |tc_ch;
            status_reg         <= status_next;
        end
    end

    assign terminal_count        = terminal_count_reg;
    assign terminal_count_status = status_reg;

endmodule

// File: tb/tb_kf8237_channel_register_bank.sv
// Directed bench for kf8237_channel_register_bank with a behavioural model
// compared on every falling clock edge, plus literal expectations.
module tb_kf8237_channel_register_bank;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  internal_data_bus = 8'h00;
    logic [3:0]  write_base_and_current_address = 4'h0;
    logic [3:0]  write_base_and_current_word_count = 4'h0;
    logic [3:0]  read_current_address = 4'h0;
    logic [3:0]  read_current_word_count = 4'h0;
    logic        clear_byte_pointer = 1'b0;
    logic        master_clear = 1'b0;
    logic        read_status_register = 1'b0;
    logic [3:0]  autoinitialize = 4'h0;
    logic [3:0]  address_decrement = 4'h0;
    logic [3:0]  active_channel = 4'h0;
    logic        update = 1'b0;
    logic        end_of_process_in = 1'b0;
    logic [7:0]  data_bus_out;
    logic [15:0] current_address_out;
    logic        terminal_count;
    logic [3:0]  terminal_count_status;
    logic [7:0]  data_bus_out_24;
    logic [23:0] current_address_out_24;
    logic        terminal_count_24;
    logic [3:0]  terminal_count_status_24;

    int errors = 0;
    int checks = 0;
    int tc_pulses = 0;

    kf8237_channel_register_bank #(.CHANNELS(4), .ADDR_WIDTH(16), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .internal_data_bus(internal_data_bus),
        .write_base_and_current_address(write_base_and_current_address),
        .write_base_and_current_word_count(write_base_and_current_word_count),
        .read_current_address(read_current_address), .read_current_word_count(read_current_word_count),
        .clear_byte_pointer(clear_byte_pointer), .master_clear(master_clear),
        .read_status_register(read_status_register), .autoinitialize(autoinitialize),
        .address_decrement(address_decrement), .active_channel(active_channel),
        .update(update), .end_of_process_in(end_of_process_in),
        .data_bus_out(data_bus_out), .current_address_out(current_address_out),
        .terminal_count(terminal_count), .terminal_count_status(terminal_count_status));

    kf8237_channel_register_bank #(.CHANNELS(4), .ADDR_WIDTH(24), .COUNT_WIDTH(16)) dut24 (
        .clock(clock), .reset(reset), .internal_data_bus(internal_data_bus),
        .write_base_and_current_address(write_base_and_current_address),
        .write_base_and_current_word_count(write_base_and_current_word_count),
        .read_current_address(read_current_address), .read_current_word_count(read_current_word_count),
        .clear_byte_pointer(clear_byte_pointer), .master_clear(master_clear),
        .read_status_register(read_status_register), .autoinitialize(autoinitialize),
        .address_decrement(address_decrement), .active_channel(active_channel),
        .update(update), .end_of_process_in(end_of_process_in),
        .data_bus_out(data_bus_out_24), .current_address_out(current_address_out_24),
        .terminal_count(terminal_count_24), .terminal_count_status(terminal_count_status_24));

    always #5 clock = ~clock;

    // ---------------- behavioural model (16-bit, 4-channel instance) ----------------
    logic [15:0] m_base_a [4];
    logic [15:0] m_cur_a  [4];
    logic [15:0] m_base_c [4];
    logic [15:0] m_cur_c  [4];
    int          m_ptr;
    logic        m_rd_prev, m_stat_prev, m_tc;
    logic [3:0]  m_status;
    int          wa, wc, ac;
    logic        tc_now, fall;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] put_byte(input logic [15:0] v, input int p, input logic [7:0] d);
        logic [15:0] r;
        r = v;
        r[p*8 +: 8] = d;
        return r;
    endfunction

    function automatic logic [7:0] exp_data();
        int ra, rc;
        ra = lowest(read_current_address);
        rc = lowest(read_current_word_count);
        if (ra >= 0) return 8'(m_cur_a[ra] >> (8 * m_ptr));
        if (rc >= 0) return 8'(m_cur_c[rc] >> (8 * m_ptr));
        return 8'h00;
    endfunction

    function automatic logic [15:0] exp_addr();
        int a;
        a = lowest(active_channel);
        return (a >= 0) ? m_cur_a[a] : 16'h0000;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_base_a[i] = 0; m_cur_a[i] = 0; m_base_c[i] = 0; m_cur_c[i] = 0;
            end
            m_ptr = 0; m_rd_prev = 0; m_stat_prev = 0; m_tc = 0; m_status = 0;
        end else begin
            wa = lowest(write_base_and_current_address);
            wc = lowest(write_base_and_current_word_count);
            ac = update ? lowest(active_channel) : -1;
            tc_now = 1'b0;
            if (ac >= 0) begin
                tc_now = (m_cur_c[ac] == 0) || end_of_process_in;
                if (wa != ac)
                    m_cur_a[ac] = (tc_now && autoinitialize[ac]) ? m_base_a[ac]
                                : (address_decrement[ac] ? m_cur_a[ac] - 16'd1 : m_cur_a[ac] + 16'd1);
                if (wc != ac)
                    m_cur_c[ac] = (tc_now && autoinitialize[ac]) ? m_base_c[ac] : m_cur_c[ac] - 16'd1;
            end
            if (wa >= 0) begin
                m_base_a[wa] = put_byte(m_base_a[wa], m_ptr, internal_data_bus);
                m_cur_a[wa]  = put_byte(m_cur_a[wa],  m_ptr, internal_data_bus);
            end
            if (wc >= 0) begin
                m_base_c[wc] = put_byte(m_base_c[wc], m_ptr, internal_data_bus);
                m_cur_c[wc]  = put_byte(m_cur_c[wc],  m_ptr, internal_data_bus);
            end
            if (master_clear || (m_stat_prev && !read_status_register)) m_status = 4'h0;
            if (tc_now) m_status[ac] = 1'b1;
            m_tc = tc_now;
            fall = m_rd_prev && !((|read_current_address) || (|read_current_word_count));
            if (clear_byte_pointer || master_clear) m_ptr = 0;
            else if (wa >= 0 || wc >= 0 || fall) m_ptr = (m_ptr + 1) % 2;
            m_rd_prev   = (|read_current_address) || (|read_current_word_count);
            m_stat_prev = read_status_register;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        check("model data_bus_out", 32'(data_bus_out), 32'(exp_data()));
        check("model current_address_out", 32'(current_address_out), 32'(exp_addr()));
        check("model terminal_count", 32'(terminal_count), 32'(m_tc));
        check("model terminal_count_status", 32'(terminal_count_status), 32'(m_status));
        if (terminal_count === 1'b1) tc_pulses++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input bit is_addr, input int ch, input logic [7:0] d);
        internal_data_bus = d;
        if (is_addr) write_base_and_current_address[ch] = 1'b1;
        else         write_base_and_current_word_count[ch] = 1'b1;
        tick();
        write_base_and_current_address = 4'h0;
        write_base_and_current_word_count = 4'h0;
        $display("write %s ch%0d byte %h", is_addr ? "addr " : "count", ch, d);
    endtask

    task automatic pulse_clear();
        clear_byte_pointer = 1'b1;
        tick();
        clear_byte_pointer = 1'b0;
    endtask

    task automatic rd(input bit is_addr, input int ch, output logic [15:0] val);
        for (int b = 0; b < 2; b++) begin
            if (is_addr) read_current_address[ch] = 1'b1;
            else         read_current_word_count[ch] = 1'b1;
            #2 val[b*8 +: 8] = data_bus_out;
            tick();
            read_current_address = 4'h0;
            read_current_word_count = 4'h0;
            tick();
        end
        $display("read  %s ch%0d = %h", is_addr ? "addr " : "count", ch, val);
    endtask

    task automatic step_once();
        update = 1'b1;
        tick();
        update = 1'b0;
        $display("update active=%b", active_channel);
    endtask

    logic [15:0] v;
    int          tc_base;

    initial begin
        #2 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("reset data_bus_out", 32'(data_bus_out), 32'h0);
        check("reset status", 32'(terminal_count_status), 32'h0);
        check("reset terminal_count", 32'(terminal_count), 32'h0);
        tick();

        // 1: ch2 address 0x1234, read twice to show the pointer returned to 0
        wr(1, 2, 8'h34); wr(1, 2, 8'h12);
        rd(1, 2, v); check("t1 ch2 addr read", 32'(v), 32'h1234);
        rd(1, 2, v); check("t1 ch2 addr reread", 32'(v), 32'h1234);

        // 2: 24-bit address register on the second instance
        pulse_clear();
        wr(1, 0, 8'h56); wr(1, 0, 8'h34); wr(1, 0, 8'h12);
        active_channel = 4'b0001; #1;
        check("t2 24-bit addr", 32'(current_address_out_24), 32'h123456);
        wr(1, 0, 8'h99); #1;
        check("t2 fourth write byte0", 32'(current_address_out_24), 32'h123499);
        active_channel = 4'h0;

        // 3: ch0 count 1, addr 0x0010 increment, two updates
        pulse_clear();
        wr(0, 0, 8'h01); wr(0, 0, 8'h00);
        wr(1, 0, 8'h10); wr(1, 0, 8'h00);
        tc_base = tc_pulses;
        step_once();                          // active=0: ignored
        active_channel = 4'b0001;
        step_once();
        rd(0, 0, v); check("t3 count after 1st", 32'(v), 32'h0000);
        step_once();
        tick(); tick();
        check("t3 addr", 32'(current_address_out), 32'h0012);
        rd(0, 0, v); check("t3 count wrapped", 32'(v), 32'hFFFF);
        check("t3 tc pulses", 32'(tc_pulses - tc_base), 32'd1);
        active_channel = 4'h0;

        // 4: ch1 autoinit, decrement, base 0x8000 / count 2, three updates
        autoinitialize[1] = 1'b1; address_decrement[1] = 1'b1;
        wr(1, 1, 8'h00); wr(1, 1, 8'h80);
        wr(0, 1, 8'h02); wr(0, 1, 8'h00);
        active_channel = 4'b0010;
        step_once(); step_once();
        check("t4 addr after 2", 32'(current_address_out), 32'h7FFE);
        step_once();
        check("t4 addr reload", 32'(current_address_out), 32'h8000);
        rd(0, 1, v); check("t4 count reload", 32'(v), 32'h0002);
        check("t4 status[1] set", 32'(terminal_count_status[1]), 32'd1);
        read_status_register = 1'b1; tick();
        read_status_register = 1'b0; tick(); tick();
        check("t4 status cleared", 32'(terminal_count_status), 32'h0);
        active_channel = 4'h0;

        // 5: CPU address write concurrent with an update on ch3
        pulse_clear();
        wr(1, 3, 8'h00); wr(1, 3, 8'h20);
        wr(0, 3, 8'h05); wr(0, 3, 8'h00);
        active_channel = 4'b1000;
        internal_data_bus = 8'hAB;
        write_base_and_current_address = 4'b1000;
        update = 1'b1;
        tick();
        write_base_and_current_address = 4'h0;
        update = 1'b0;
        check("t5 addr is cpu byte", 32'(current_address_out), 32'h20AB);
        pulse_clear();
        rd(0, 3, v); check("t5 count stepped", 32'(v), 32'h0004);
        active_channel = 4'h0;

        // 6: reset in the middle of a two-byte read
        pulse_clear();
        read_current_address[2] = 1'b1; #2;
        check("t6 byte0 before reset", 32'(data_bus_out), 32'h34);
        tick();
        read_current_address = 4'h0;
        tick();
        read_current_address[2] = 1'b1;
        active_channel = 4'b0001; update = 1'b1; end_of_process_in = 1'b1;
        #2 reset = 1'b1;
        #1 check("t6 data in reset", 32'(data_bus_out), 32'h0);
        tick();
        reset = 1'b0;
        read_current_address = 4'h0; update = 1'b0; end_of_process_in = 1'b0;
        active_channel = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6 no tc pulse", 32'(terminal_count), 32'd0);
        end
        wr(1, 2, 8'hCD);
        active_channel = 4'b0100; #1;
        check("t6 ptr reset to 0", 32'(current_address_out), 32'h00CD);
        active_channel = 4'h0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
